amp_seq_ctrl: RTL and testbench

Power/mute sequencer for the external amplifier behind the toi2s front end, running on the 50 MHz system clock.
- Enables the amp only after the serial audio input has locked.
- Unmutes only after the amp power-up delay; on shutdown, mutes before disabling.
- Handles amp error reports (nerror_in) with timed auto-retry, latching the fault after repeated failures.

---
 rtl/amp_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_amp_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/amp_seq_ctrl.sv
// Power/mute sequencer for the external amp: enable after lock, unmute after power-up, mute before disable, fault retry/latch.
// Latency: all outputs registered and move with the state; error reaction within ERR_FILT+3 edges of nerror_in falling.
// Backpressure: none; level inputs are sampled every cycle, fault_clear is a single-cycle pulse.
module amp_seq_ctrl #(
   parameter int T_EN_CYC    = 50000,
   parameter int T_MUTE_CYC  = 25000,
   parameter int T_RETRY_CYC = 500000,
   parameter int ERR_FILT    = 8,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       sw_enable,
   input  logic       lock_in,
   input  logic       nerror_in,
   input  logic       fault_clear,
   output logic       nenable_out,
   output logic       nmute_out,
   output logic [2:0] state,
   output logic [2:0] retry_cnt,
   output logic       fault_latched
);

   typedef enum logic [2:0] {
      ST_OFF        = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_POWER_UP   = 3'd2,
      ST_RUN        = 3'd3,
      ST_MUTE_DOWN  = 3'd4,
      ST_FAULT_WAIT = 3'd5,
      ST_LATCHED    = 3'd6,
      ST_UNUSED     = 3'd7
   } state_t;

   localparam int          FW        = $clog2(ERR_FILT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(ERR_FILT - 1);
   localparam logic [19:0] TMR_EN    = 20'(T_EN_CYC - 1);
   localparam logic [19:0] TMR_MUTE  = 20'(T_MUTE_CYC - 1);
   localparam logic [19:0] TMR_RETRY = 20'(T_RETRY_CYC - 1);
   localparam logic [2:0]  MAX_R     = 3'(MAX_RETRY);

   state_t        cur_st, nxt_st;
   logic [19:0]   timer, timer_nxt;
   logic [2:0]    retry_nxt, retry_base, retry_inc;
   logic          nenable_nxt, nmute_nxt, latched_nxt;
   logic          fault_go, tmr_exp;

   logic [1:0]    err_sync;
   logic          err_low;
   logic          err_f;
   logic [FW-1:0] filt_cnt;

   // nerror_in is an asynchronous pin; idle level is high
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         err_sync <= 2'b11;
      end else begin
         err_sync <= {err_sync[0], nerror_in};
      end
   end

   assign err_low = ~err_sync[1];

   // err_f flips only after ERR_FILT consecutive cycles disagreeing with it
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         err_f    <= 1'b0;
         filt_cnt <= '0;
      end else if (err_low == err_f) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         err_f    <= err_low;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cur_st        <= ST_OFF;
         timer         <= '0;
         retry_cnt     <= '0;
         nenable_out   <= 1'b1;
         nmute_out     <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         cur_st        <= nxt_st;
         timer         <= timer_nxt;
         retry_cnt     <= retry_nxt;
         nenable_out   <= nenable_nxt;
         nmute_out     <= nmute_nxt;
         fault_latched <= latched_nxt;
      end
   end

   assign state = cur_st;

   always_comb begin
      nxt_st     = cur_st;
      fault_go   = 1'b0;
      tmr_exp    = (timer == '0);
      // a clear coinciding with a fault entry is applied before the increment
      retry_base = fault_clear ? 3'd0 : retry_cnt;
      retry_inc  = (retry_base < MAX_R) ? retry_base + 3'd1 : retry_base;
      retry_nxt  = retry_base;

      case (cur_st)
         ST_OFF: begin
            if (sw_enable) nxt_st = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (!sw_enable)   nxt_st = ST_OFF;
            else if (lock_in) nxt_st = ST_POWER_UP;
         end
         ST_POWER_UP: begin
            if (err_f)           fault_go = 1'b1;
            else if (!sw_enable) nxt_st   = ST_OFF;
            else if (!lock_in)   nxt_st   = ST_WAIT_LOCK;
            else if (tmr_exp)    nxt_st   = ST_RUN;
         end
         ST_RUN: begin
            if (err_f)                       fault_go  = 1'b1;
            else if (!sw_enable || !lock_in) nxt_st    = ST_MUTE_DOWN;
            else if (tmr_exp)                retry_nxt = 3'd0;
         end
         ST_MUTE_DOWN: begin
            if (err_f)        fault_go = 1'b1;
            else if (tmr_exp) nxt_st   = sw_enable ? ST_WAIT_LOCK : ST_OFF;
         end
         ST_FAULT_WAIT: begin
            if (!sw_enable)             nxt_st = ST_OFF;
            else if (tmr_exp && !err_f) nxt_st = ST_WAIT_LOCK;
         end
         ST_LATCHED: begin
            if (fault_clear) nxt_st = ST_OFF;
         end
         default: nxt_st = ST_OFF;
      endcase

      if (fault_go) begin
         retry_nxt = retry_inc;
         nxt_st    = (retry_inc == MAX_R) ? ST_LATCHED : ST_FAULT_WAIT;
      end

      if (nxt_st != cur_st) begin
         case (nxt_st)
            ST_POWER_UP:   timer_nxt = TMR_EN;
            ST_RUN:        timer_nxt = TMR_RETRY;
            ST_MUTE_DOWN:  timer_nxt = TMR_MUTE;
            ST_FAULT_WAIT: timer_nxt = TMR_RETRY;
            default:       timer_nxt = '0;
         endcase
      end else if (!tmr_exp) begin
         timer_nxt = timer - 20'd1;
      end else begin
         timer_nxt = '0;
      end

      // nmute only in RUN, and RUN always has the amp enabled
      nenable_nxt = !(nxt_st == ST_POWER_UP || nxt_st == ST_RUN || nxt_st == ST_MUTE_DOWN);
      nmute_nxt   = (nxt_st == ST_RUN);
      latched_nxt = (nxt_st == ST_LATCHED);
   end

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Directed bench for amp_seq_ctrl with shortened timing parameters.
module tb_amp_seq_ctrl;

   logic       clk;
   logic       resetb;
   logic       sw_enable;
   logic       lock_in;
   logic       nerror_in;
   logic       fault_clear;
   logic       nenable_out;
   logic       nmute_out;
   logic [2:0] state;
   logic [2:0] retry_cnt;
   logic       fault_latched;

   int checks   = 0;
   int failures = 0;
   int inv_viol = 0;

   amp_seq_ctrl #(
      .T_EN_CYC   (10),
      .T_MUTE_CYC (5),
      .T_RETRY_CYC(20),
      .ERR_FILT   (4),
      .MAX_RETRY  (3)
   ) dut (
      .clk          (clk),
      .resetb       (resetb),
      .sw_enable    (sw_enable),
      .lock_in      (lock_in),
      .nerror_in    (nerror_in),
      .fault_clear  (fault_clear),
      .nenable_out  (nenable_out),
      .nmute_out    (nmute_out),
      .state        (state),
      .retry_cnt    (retry_cnt),
      .fault_latched(fault_latched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (nmute_out === 1'b1 && nenable_out !== 1'b0) inv_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_st(input string tag, input logic [2:0] s, input logic ne, input logic nm);
      chk({tag, "_state"}, 32'(state), 32'(s));
      chk({tag, "_nen"}, 32'(nenable_out), 32'(ne));
      chk({tag, "_nmute"}, 32'(nmute_out), 32'(nm));
   endtask

   initial begin
      resetb      = 1'b1;
      sw_enable   = 1'b0;
      lock_in     = 1'b0;
      nerror_in   = 1'b1;
      fault_clear = 1'b0;
      #1 resetb = 1'b0;
      #3;
      chk_st("reset", 3'd0, 1'b1, 1'b0);
      chk("reset_retry", 32'(retry_cnt), 0);
      chk("reset_latched", 32'(fault_latched), 0);
      @(posedge clk);
      @(posedge clk);
      #1 resetb = 1'b1;

      // 1. startup: wait for lock, then power-up delay to RUN
      sw_enable = 1'b1;
      step(50);
      chk_st("wait_lock", 3'd1, 1'b1, 1'b0);
      lock_in = 1'b1;
      step(1);
      chk_st("pu_entry", 3'd2, 1'b0, 1'b0);
      step(9);
      chk_st("pu_late", 3'd2, 1'b0, 1'b0);
      step(1);
      chk_st("run_entry", 3'd3, 1'b0, 1'b1);

      // 2. orderly stop: mute first, disable five cycles later
      sw_enable = 1'b0;
      step(1);
      chk_st("md_entry", 3'd4, 1'b0, 1'b0);
      step(4);
      chk_st("md_late", 3'd4, 1'b0, 1'b0);
      step(1);
      chk_st("stop_off", 3'd0, 1'b1, 1'b0);

      // back to RUN
      sw_enable = 1'b1;
      step(2);
      chk("rerun_pu", 32'(state), 2);
      step(10);
      chk_st("rerun", 3'd3, 1'b0, 1'b1);

      // 3. glitch rejection, then a real error
      nerror_in = 1'b0;
      step(3);
      nerror_in = 1'b1;
      step(10);
      chk_st("glitch", 3'd3, 1'b0, 1'b1);
      nerror_in = 1'b0;
      step(6);
      chk_st("err_edge6", 3'd3, 1'b0, 1'b1);
      step(1);
      chk_st("err_edge7", 3'd5, 1'b1, 1'b0);
      chk("err_retry1", 32'(retry_cnt), 1);

      // 4. retry after back-off, then retry_cnt clears after a full RUN period
      step(3);
      nerror_in = 1'b1;
      step(16);
      chk("fw_hold", 32'(state), 5);
      step(1);
      chk("fw_exit", 32'(state), 1);
      step(1);
      chk("retry_pu", 32'(state), 2);
      step(10);
      chk_st("retry_run", 3'd3, 1'b0, 1'b1);
      step(19);
      chk("run_retry_kept", 32'(retry_cnt), 1);
      step(1);
      chk("run_retry_clr", 32'(retry_cnt), 0);

      // 5. three quick faults latch the block
      nerror_in = 1'b0;
      step(7);
      chk("f1_state", 32'(state), 5);
      chk("f1_retry", 32'(retry_cnt), 1);
      nerror_in = 1'b1;
      step(20);
      chk("f1_wait_lock", 32'(state), 1);
      step(1);
      nerror_in = 1'b0;
      step(7);
      chk("f2_state", 32'(state), 5);
      chk("f2_retry", 32'(retry_cnt), 2);
      nerror_in = 1'b1;
      step(21);
      chk("f2_pu", 32'(state), 2);
      nerror_in = 1'b0;
      step(7);
      chk_st("latched", 3'd6, 1'b1, 1'b0);
      chk("latched_flag", 32'(fault_latched), 1);
      chk("latched_retry", 32'(retry_cnt), 3);
      nerror_in = 1'b1;
      sw_enable = 1'b0;
      step(3);
      chk("latched_swoff", 32'(state), 6);
      sw_enable = 1'b1;
      step(3);
      chk("latched_swon", 32'(state), 6);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      chk_st("clear_off", 3'd0, 1'b1, 1'b0);
      chk("clear_retry", 32'(retry_cnt), 0);
      chk("clear_flag", 32'(fault_latched), 0);

      // 6. asynchronous reset in the middle of RUN
      step(12);
      chk_st("pre_reset_run", 3'd3, 1'b0, 1'b1);
      #3 resetb = 1'b0;
      #1;
      chk_st("async_reset", 3'd0, 1'b1, 1'b0);
      #2 resetb = 1'b1;
      #1;
      chk("rel_state", 32'(state), 0);
      chk("rel_retry", 32'(retry_cnt), 0);
      step(2);

      chk("invariant", 32'(inv_viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
